// File: rtl/hw_io_pkg.sv
// Shared I/O definitions for the hardware-safety top: channel map,
// reset levels of the filtered inputs and default debounce timing.
package hw_io_pkg;

  localparam int HW_N_CH       = 32;
  localparam int HW_DEB_W      = 16;
  localparam int HW_DEB_CYCLES = 1000;
  localparam int HW_SYNC_STG   = 2;

  localparam int CH_ILK_SINK_0   = 0;
  localparam int CH_ILK_SINK_7   = 7;
  localparam int CH_DOOR_A_N     = 8;
  localparam int CH_DOOR_B_N     = 9;
  localparam int CH_PEND_EN      = 10;
  localparam int CH_PEND_ESTOP_N = 11;
  localparam int CH_OSSD_A       = 12;
  localparam int CH_OSSD_B       = 13;
  localparam int CH_EMO_N        = 14;
  localparam int CH_CFG_0        = 16;
  localparam int CH_CFG_15       = 31;

  function automatic logic [HW_N_CH-1:0] ch_bit(input int idx);
    logic [HW_N_CH-1:0] one;
    one = 1;
    return one << idx;
  endfunction

  // Idle level of active-low and safety-OK-high channels is 1.
  localparam logic [HW_N_CH-1:0] HW_IN_RESET_VAL =
      ch_bit(CH_DOOR_A_N) | ch_bit(CH_DOOR_B_N)
    | ch_bit(CH_PEND_ESTOP_N) | ch_bit(CH_OSSD_A)
    | ch_bit(CH_OSSD_B) | ch_bit(CH_EMO_N);

endpackage

// File: rtl/hw_deb_ch.sv
// One input channel: synchronizer chain, consecutive-sample debounce,
// filtered level and one-cycle rise/fall pulses.
// Ports: CLK_100M, RST, pin_i -> filt_o, rise_o, fall_o.
module hw_deb_ch
  import hw_io_pkg::*;
#(
  parameter int   SYNC_STAGES = HW_SYNC_STG,
  parameter int   DEB_CYCLES  = HW_DEB_CYCLES,
  parameter int   DEB_W       = HW_DEB_W,
  parameter logic RESET_BIT   = 1'b0
) (
  input  logic CLK_100M,
  input  logic RST,
  input  logic pin_i,
  output logic filt_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [DEB_W-1:0] LAST = DEB_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [DEB_W-1:0]       cnt;
  logic                   sync_q;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      sync_r <= {SYNC_STAGES{RESET_BIT}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], pin_i};
    end
  end

  // cnt holds the number of consecutive differing samples already
  // seen; the DEB_CYCLES-th one is accepted, so cnt never passes LAST.
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      cnt    <= '0;
      filt_o <= RESET_BIT;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (sync_q == filt_o) begin
        cnt <= '0;
      end else if (cnt >= LAST) begin
        cnt    <= '0;
        filt_o <= sync_q;
        rise_o <= sync_q;
        fall_o <= ~sync_q;
      end else begin
        cnt <= cnt + DEB_W'(1);
      end
    end
  end

endmodule

// File: rtl/hw_input_filter.sv
// Input conditioning for all external status pins: per-channel sync +
// debounce, edge pulses and sticky change flags with masked clear.
// Ports: CLK_100M, RST, pin_i, clr_i, clr_mask_i ->
//        filt_o, rise_o, fall_o, chg_sticky_o.
module hw_input_filter
  import hw_io_pkg::*;
#(
  parameter int              N_CH        = HW_N_CH,
  parameter int              SYNC_STAGES = HW_SYNC_STG,
  parameter int              DEB_CYCLES  = HW_DEB_CYCLES,
  parameter int              DEB_W       = HW_DEB_W,
  parameter logic [N_CH-1:0] RESET_VAL   = '0
) (
  input  logic            CLK_100M,
  input  logic            RST,
  input  logic [N_CH-1:0] pin_i,
  output logic [N_CH-1:0] filt_o,
  output logic [N_CH-1:0] rise_o,
  output logic [N_CH-1:0] fall_o,
  output logic [N_CH-1:0] chg_sticky_o,
  input  logic            clr_i,
  input  logic [N_CH-1:0] clr_mask_i
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    hw_deb_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_CYCLES (DEB_CYCLES),
      .DEB_W      (DEB_W),
      .RESET_BIT  (RESET_VAL[i])
    ) u_ch (
      .CLK_100M(CLK_100M),
      .RST     (RST),
      .pin_i   (pin_i[i]),
      .filt_o  (filt_o[i]),
      .rise_o  (rise_o[i]),
      .fall_o  (fall_o[i])
    );
  end

  logic [N_CH-1:0] clr_vec;

  assign clr_vec = {N_CH{clr_i}} & clr_mask_i;

  // Set is OR-ed in after the clear so a same-edge event survives.
  always_ff @(posedge CLK_100M) begin
    if (RST) begin
      chg_sticky_o <= '0;
    end else begin
      chg_sticky_o <= (chg_sticky_o & ~clr_vec) | rise_o | fall_o;
    end
  end

endmodule

// File: tb/tb_hw_input_filter.sv
// Scoreboard bench for hw_input_filter: window-based reference model,
// directed scenarios plus random pin activity.
module tb_hw_input_filter;

  localparam int          N   = 32;
  localparam int          DEB = 4;
  localparam logic [31:0] RV  = 32'hFFFF_0000;

  typedef struct {
    logic [31:0] f;
    logic [31:0] r;
    logic [31:0] fl;
    logic [31:0] s;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pin = RV;
  logic        clr = 1'b0;
  logic [31:0] mask = '0;
  logic [31:0] filt, rise, fall, stk;

  int checks = 0;
  int errors = 0;

  exp_t        exp_q[$];
  logic [31:0] pipe[$];
  logic [31:0] hist[$];
  logic [31:0] m_filt, m_rise, m_fall, m_stk;

  always #5 clk = ~clk;

  hw_input_filter #(
    .N_CH       (N),
    .SYNC_STAGES(2),
    .DEB_CYCLES (DEB),
    .DEB_W      (16),
    .RESET_VAL  (RV)
  ) dut (
    .CLK_100M    (clk),
    .RST         (rst),
    .pin_i       (pin),
    .filt_o      (filt),
    .rise_o      (rise),
    .fall_o      (fall),
    .chg_sticky_o(stk),
    .clr_i       (clr),
    .clr_mask_i  (mask)
  );

  // A channel flips when its last DEB synchronized samples since reset
  // all disagree with the current filtered level.
  task automatic model_step();
    logic [31:0] sq, nr, nf, cm;
    exp_t e;
    if (rst) begin
      m_filt = RV;
      m_rise = '0;
      m_fall = '0;
      m_stk  = '0;
      pipe.delete();
      pipe.push_back(RV);
      pipe.push_back(RV);
      hist.delete();
    end else begin
      sq = pipe.pop_front();
      pipe.push_back(pin);
      hist.push_back(sq);
      if (hist.size() > DEB) void'(hist.pop_front());
      cm = clr ? mask : '0;
      m_stk = (m_stk & ~cm) | m_rise | m_fall;
      nr = '0;
      nf = '0;
      if (hist.size() == DEB) begin
        for (int c = 0; c < N; c++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][c] == m_filt[c]) all_diff = 1'b0;
          if (all_diff) begin
            m_filt[c] = ~m_filt[c];
            if (m_filt[c]) nr[c] = 1'b1;
            else nf[c] = 1'b1;
          end
        end
      end
      m_rise = nr;
      m_fall = nf;
    end
    e.f  = m_filt;
    e.r  = m_rise;
    e.fl = m_fall;
    e.s  = m_stk;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic chk1(input string nm, input logic a, input logic b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, a, b);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks += 4;
      if (filt !== e.f) begin
        errors++;
        $display("FAIL filt_o @%0t: got %h expected %h", $time, filt, e.f);
      end
      if (rise !== e.r) begin
        errors++;
        $display("FAIL rise_o @%0t: got %h expected %h", $time, rise, e.r);
      end
      if (fall !== e.fl) begin
        errors++;
        $display("FAIL fall_o @%0t: got %h expected %h", $time, fall, e.fl);
      end
      if (stk !== e.s) begin
        errors++;
        $display("FAIL sticky @%0t: got %h expected %h", $time, stk, e.s);
      end
    end
  end

  initial begin
    cyc(2);
    rst = 1'b0;
    cyc(3);

    // Channel 0 rise: accepted exactly on edge 6.
    pin[0] = 1'b1;
    cyc(5);
    chk1("lat_pre_filt0", filt[0], 1'b0);
    cyc(1);
    chk1("lat_filt0", filt[0], 1'b1);
    chk1("lat_rise0", rise[0], 1'b1);
    cyc(1);
    chk1("rise0_width", rise[0], 1'b0);
    chk1("sticky0_set", stk[0], 1'b1);
    cyc(2);

    // Channel 3: 3-cycle glitch rejected, 4-cycle pulse accepted.
    pin[3] = 1'b1;
    cyc(3);
    pin[3] = 1'b0;
    cyc(8);
    chk1("glitch3_filt", filt[3], 1'b0);
    chk1("glitch3_sticky", stk[3], 1'b0);
    pin[3] = 1'b1;
    cyc(4);
    pin[3] = 1'b0;
    cyc(3);
    chk1("pulse3_accept", filt[3], 1'b1);
    cyc(8);

    // Simultaneous channels 7:4.
    pin[7:4] = 4'hF;
    cyc(6);
    chk1("multi_rise", &rise[7:4], 1'b1);
    cyc(3);

    // Set-wins on channel 2, then a lone clear.
    pin[2] = 1'b1;
    cyc(10);
    clr  = 1'b1;
    mask = '1;
    cyc(1);
    clr  = 1'b0;
    mask = '0;
    pin[2] = 1'b0;
    cyc(6);
    chk1("fall2", fall[2], 1'b1);
    clr  = 1'b1;
    mask = 32'h0000_0004;
    cyc(1);
    chk1("setwins2", stk[2], 1'b1);
    cyc(1);
    clr = 1'b0;
    chk1("clear2", stk[2], 1'b0);
    mask = '0;
    cyc(2);

    // Reset while channel 1 counter is at 2.
    pin[1] = 1'b1;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(5);
    chk1("rst_mid_pre", filt[1], 1'b0);
    cyc(1);
    chk1("rst_mid_post", filt[1], 1'b1);
    cyc(3);

    // Random activity with occasional clears and resets.
    for (int t = 0; t < 1500; t++) begin
      pin  = pin ^ ($urandom & $urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) pin = pin ^ ($urandom & $urandom);
      clr  = ($urandom_range(0, 9) == 0);
      mask = $urandom;
      rst  = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0;
    clr = 1'b0;
    cyc(2);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hw_input_filter.md
# hw_input_filter

Conditioning stage between the board input pins and the registered input capture of the hardware-safety FPGA top level. Every external status input (interlock sink states, door switches, pendant, laser-scanner OSSD, EMO, config switches) passes through a per-channel synchronizer and a consecutive-sample debounce filter. The block emits clean levels, single-cycle edge pulses and sticky change flags that downstream logic consumes instead of raw pins.

## Interface
- N_CH, 32, number of input channels
- SYNC_STAGES, 2, flip-flops in each synchronizer chain (>=2)
- DEB_CYCLES, 1000, consecutive clocks a new level must persist before acceptance (10 us at 100 MHz); legal range 1..2^DEB_W-1
- DEB_W, 16, debounce counter width
- RESET_VAL, {N_CH{1'b0}}, per-channel reset level of the filtered output (1 for active-low `_N` inputs)

- CLK_100M  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- pin_i  in  N_CH  raw asynchronous pin inputs
- filt_o  out  N_CH  debounced levels
- rise_o  out  N_CH  one-cycle pulse, filtered 0->1
- fall_o  out  N_CH  one-cycle pulse, filtered 1->0
- chg_sticky_o  out  N_CH  latched "changed since last clear"
- clr_i  in  1  clear strobe for sticky flags
- clr_mask_i  in  N_CH  channels cleared by clr_i

## Operation
- Reset (RST high at an edge): sync chains load RESET_VAL, filt_o = RESET_VAL, counters = 0, rise_o = fall_o = 0, chg_sticky_o = 0.
- Sync: pin_i shifts through SYNC_STAGES flops; last stage is sync_q. No logic between the stages.
- Debounce, per channel, each edge:
  - sync_q == filt_o: cnt <= 0.
  - sync_q != filt_o and cnt < DEB_CYCLES-1: cnt <= cnt+1.
  - sync_q != filt_o and cnt == DEB_CYCLES-1: filt_o <= sync_q, cnt <= 0, assert rise_o or fall_o for exactly that next cycle.
- Any return of sync_q to filt_o before acceptance zeroes cnt (glitch rejected, no event).
- Counter saturates at DEB_CYCLES-1; it never wraps.
- Sticky: chg_sticky_o[i] sets on rise_o[i]|fall_o[i]; clears when clr_i & clr_mask_i[i]. If set and clear occur on the same edge, set wins.
- Channels are fully independent; simultaneous transitions on any subset are all reported in the same cycle.
- No handshake on outputs; consumers sample every cycle.

## Timing
- Latency: a pin level stable before sampling edge 1 appears on filt_o after edge SYNC_STAGES+DEB_CYCLES (edge 6 for 2/4).
- rise_o/fall_o coincide with the first cycle filt_o shows the new level; width one cycle.
- Sticky set visible one cycle after the edge pulse; clear visible the cycle after clr_i.
- RST mid-count: counter discarded, no event generated; if pin differs from RESET_VAL after release, full latency restarts.
- DEB_CYCLES = 1: filt_o follows sync_q with one extra register.
- Minimum accepted pulse width: DEB_CYCLES clocks; shorter pulses never reach filt_o.

## Structure
- Shared package hw_io_pkg: HW_N_CH, channel index constants for each named input, HW_IN_RESET_VAL mask (1s for `_N` and OSSD/EMO channels), default DEB_CYCLES.
- Sub-module hw_deb_ch: one channel (sync chain, counter, level, edge pulses), instantiated N_CH times via generate; sticky logic stays in the top of this block.

## Test plan
- Reset with RESET_VAL=32'hFFFF_0000 -> filt_o=32'hFFFF_0000, rise_o=fall_o=chg_sticky_o=0 on first cycle after RST.
- SYNC_STAGES=2, DEB_CYCLES=4, pin_i[0] 0->1 held -> filt_o[0]=1 after edge 6, rise_o[0]=1 for that single cycle, chg_sticky_o[0]=1 next cycle.
- pin_i[3] high for 3 cycles then low, DEB_CYCLES=4 -> filt_o[3] stays 0, no pulses, sticky stays 0; repeat with 4 cycles -> accepted.
- pin_i[7:4] toggled on the same edge -> four rise_o bits asserted in the same cycle, filt_o[7:4]=4'hF.
- clr_i=1, clr_mask_i bit 2 set on the same edge a fall_o[2] sets sticky -> chg_sticky_o[2]=1 (set wins); clr_i alone next cycle -> 0.
- RST pulsed while channel 1 counter=2 -> no event after release; pin still differing -> filt_o[1] changes after full 6-edge latency measured from release.
